// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : adder_arbiter
// Description : Round-robin arbiter sharing one WIDTH-bit adder among NREQ
//               requesters.
//               Define ADDER_ARB_FIXED_PRIO_EN for fixed priority (index 0 highest).
// Revision    : 1.0 - initial release
// ============================================================================
module adder_arbiter #(
   parameter int WIDTH = 32,
   parameter int NREQ  = 3,
   parameter int IDW   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_i,
   input  logic [NREQ*WIDTH-1:0] a_i,
   input  logic [NREQ*WIDTH-1:0] b_i,
   output logic [NREQ-1:0]       ack_o,
   output logic [WIDTH-1:0]      sum_o,
   output logic [IDW-1:0]        gnt_id_o,
   output logic                  busy_o
);

   logic [NREQ-1:0]  ack_q,    ack_d;
   logic [WIDTH-1:0] sum_q,    sum_d;
   logic [IDW-1:0]   gnt_id_q, gnt_id_d;

   logic [NREQ-1:0]  w_eligible;
   logic             w_gnt_valid;
   logic [IDW-1:0]   w_gnt_idx;
   logic [WIDTH-1:0] w_op_a;
   logic [WIDTH-1:0] w_op_b;

   // The requester acked this cycle is masked so one request is never served twice.
   assign w_eligible = req_i & ~ack_q;
   assign busy_o     = |w_eligible;

`ifdef ADDER_ARB_FIXED_PRIO_EN
   always_comb begin
      w_gnt_valid = 1'b0;
      w_gnt_idx   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (w_eligible[k]) begin
            w_gnt_valid = 1'b1;
            w_gnt_idx   = IDW'(k);
         end
      end
   end
`else
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   logic           w_hi_valid, w_lo_valid;
   logic [IDW-1:0] w_hi_idx,   w_lo_idx;

   // Lowest eligible index at or above the pointer wins; otherwise wrap to the lowest overall.
   always_comb begin
      w_hi_valid = 1'b0;
      w_hi_idx   = '0;
      w_lo_valid = 1'b0;
      w_lo_idx   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (w_eligible[k]) begin
            w_lo_valid = 1'b1;
            w_lo_idx   = IDW'(k);
            if (k >= int'(rr_ptr_q)) begin
               w_hi_valid = 1'b1;
               w_hi_idx   = IDW'(k);
            end
         end
      end
      w_gnt_valid = w_hi_valid | w_lo_valid;
      w_gnt_idx   = w_hi_valid ? w_hi_idx : w_lo_idx;
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (w_gnt_valid) begin
         rr_ptr_d = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`endif

   always_comb begin
      w_op_a = '0;
      w_op_b = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (w_gnt_idx == IDW'(k)) begin
            w_op_a = a_i[k*WIDTH +: WIDTH];
            w_op_b = b_i[k*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      sum_d    = sum_q;
      gnt_id_d = gnt_id_q;
      ack_d    = '0;
      if (w_gnt_valid) begin
         sum_d    = w_op_a + w_op_b;
         gnt_id_d = w_gnt_idx;
         for (int k = 0; k < NREQ; k++) begin
            ack_d[k] = (w_gnt_idx == IDW'(k));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_q    <= '0;
         sum_q    <= '0;
         gnt_id_q <= '0;
      end else begin
         ack_q    <= ack_d;
         sum_q    <= sum_d;
         gnt_id_q <= gnt_id_d;
      end
   end

   assign ack_o    = ack_q;
   assign sum_o    = sum_q;
   assign gnt_id_o = gnt_id_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_arbiter
// Description : Directed and randomized bench for adder_arbiter with a
//               queue-free arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_arbiter;

   localparam int WIDTH = 32;
   localparam int NREQ  = 3;
   localparam int IDW   = 2;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] a;
   logic [NREQ*WIDTH-1:0] b;
   logic [NREQ-1:0]       ack_o;
   logic [WIDTH-1:0]      sum_o;
   logic [IDW-1:0]        gnt_id_o;
   logic                  busy_o;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int               m_ack_idx;
   int               m_ptr;
   logic [WIDTH-1:0] m_sum;
   int               m_gnt;

   always #5 clk = ~clk;

   adder_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_i    (req),
      .a_i      (a),
      .b_i      (b),
      .ack_o    (ack_o),
      .sum_o    (sum_o),
      .gnt_id_o (gnt_id_o),
      .busy_o   (busy_o)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] elig, input int ptr);
`ifdef ADDER_ARB_FIXED_PRIO_EN
      for (int i = 0; i < NREQ; i++) if (elig[i]) return i;
`else
      for (int off = 0; off < NREQ; off++) begin
         int k;
         k = (ptr + off) % NREQ;
         if (elig[k]) return k;
      end
`endif
      return -1;
   endfunction

   task automatic model_reset();
      m_ack_idx = -1;
      m_ptr     = 0;
      m_sum     = '0;
      m_gnt     = 0;
   endtask

   task automatic set_op(input int k, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
      a[k*WIDTH +: WIDTH] = av;
      b[k*WIDTH +: WIDTH] = bv;
   endtask

   // Called just after a rising edge with fresh inputs; checks busy, then the next edge's outputs.
   task automatic step();
      logic [NREQ-1:0] mask;
      logic [NREQ-1:0] elig;
      logic [NREQ-1:0] exp_ack;
      int g;
      mask = '0;
      if (m_ack_idx >= 0) mask[m_ack_idx] = 1'b1;
      elig = req & ~mask;
      #1;
      check_eq("busy", 64'(busy_o), 64'(|elig));
      g = pick(elig, m_ptr);
      @(posedge clk);
      #1;
      if (g >= 0) begin
         m_sum     = a[g*WIDTH +: WIDTH] + b[g*WIDTH +: WIDTH];
         m_gnt     = g;
         m_ptr     = (g + 1) % NREQ;
         m_ack_idx = g;
      end else begin
         m_ack_idx = -1;
      end
      exp_ack = '0;
      if (m_ack_idx >= 0) exp_ack[m_ack_idx] = 1'b1;
      check_eq("ack", 64'(ack_o), 64'(exp_ack));
      check_eq("gnt_id", 64'(gnt_id_o), 64'(m_gnt));
      check_eq("sum", 64'(sum_o), 64'(m_sum));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = '0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   logic [NREQ-1:0] seq_ack [6];

   initial begin
      rst_n = 1'b0;
      req   = '0;
      a     = '0;
      b     = '0;
      model_reset();
      #2;
      check_eq("reset_ack", 64'(ack_o), 64'd0);
      check_eq("reset_sum", 64'(sum_o), 64'd0);
      check_eq("reset_gnt", 64'(gnt_id_o), 64'd0);
      do_reset();

      // Single requester: served once, then masked while held
      set_op(0, 32'd5, 32'd7);
      req = 3'b001;
      step();
      check_eq("single_ack", 64'(ack_o), 64'b001);
      check_eq("single_sum", 64'(sum_o), 64'd12);
      step();
      check_eq("single_masked", 64'(ack_o), 64'b000);
      req = '0;
      step();

      // Carry out of the top bit is discarded
      set_op(1, 32'hFFFF_FFFF, 32'd2);
      req = 3'b010;
      step();
      check_eq("wrap_sum", 64'(sum_o), 64'd1);
      req = '0;
      step();

      // All three continuously requesting from reset
`ifdef ADDER_ARB_FIXED_PRIO_EN
      seq_ack = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010};
`else
      seq_ack = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`endif
      do_reset();
      for (int k = 0; k < NREQ; k++) set_op(k, WIDTH'(k * 10), 32'd1);
      req = 3'b111;
      for (int i = 0; i < 6; i++) begin
         step();
         check_eq($sformatf("seq_ack%0d", i), 64'(ack_o), 64'(seq_ack[i]));
      end

      // Asynchronous reset in the middle of a grant
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_ack", 64'(ack_o), 64'd0);
      check_eq("async_rst_sum", 64'(sum_o), 64'd0);
      check_eq("async_rst_gnt", 64'(gnt_id_o), 64'd0);
      req = '0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Randomized traffic following the requester protocol
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int k = 0; k < NREQ; k++) begin
            if (m_ack_idx == k) begin
               if ($urandom_range(1, 0) == 0) req[k] = 1'b0;
               else set_op(k, $urandom(), $urandom());
            end else if (req[k]) begin
               if ($urandom_range(19, 0) == 0) req[k] = 1'b0;
            end else if ($urandom_range(9, 0) < 4) begin
               req[k] = 1'b1;
               if ($urandom_range(7, 0) == 0) set_op(k, 32'hFFFF_FFFF, $urandom());
               else set_op(k, $urandom(), $urandom());
            end
         end
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
